// File: rtl/mcp_control_fsm.sv
// mcp_control_fsm -- multicycle MIPS control unit (Moore FSM).
//
// Sequences each instruction through FETCH/DECODE and the per-class execution
// states, and drives the datapath controls decoded from the current state.
//
// Ports:
//   CLK        in   sole clock, rising edge
//   RST        in   asynchronous, active-high reset
//   Opcode     in   [5:0] instruction opcode (from the instruction register)
//   Zero       in   ALU zero flag
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA
//              out  single-bit datapath controls
//   ALUSrcB, ALUOp, PCSrc
//              out  [1:0] mux selects / ALU decoder opcode
//   PCEn       out  PC register enable
//   State      out  [3:0] current state code (debug)
//
// Build option:
//   MCP_BNE_EN  when defined, adds the BNEBR state and decodes opcode 000101
//               (bne). When undefined, 000101 is an unknown opcode (NOP).

module mcp_control_fsm (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] State
);

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MCP_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
`ifdef MCP_BNE_EN
        ,
        StBneBr   = 4'd12
`endif
    } state_t;

    state_t state_q;

    // Opcode is only looked at in DECODE and MEMADR; every other state has a
    // fixed successor.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch: state_q <= StDecode;
                StDecode: begin
                    case (Opcode)
                        OpLw, OpSw: state_q <= StMemAdr;
                        OpRtype:    state_q <= StExecute;
                        OpBeq:      state_q <= StBranch;
                        OpAddi:     state_q <= StAddiEx;
                        OpJ:        state_q <= StJump;
`ifdef MCP_BNE_EN
                        OpBne:      state_q <= StBneBr;
`endif
                        // Unknown instruction: back to FETCH with no writes.
                        default:    state_q <= StFetch;
                    endcase
                end
                StMemAdr:  state_q <= (Opcode == OpLw) ? StMemRd : StMemWr;
                StMemRd:   state_q <= StMemWb;
                StExecute: state_q <= StAluWb;
                StAddiEx:  state_q <= StAddiWb;
                default:   state_q <= StFetch;
            endcase
        end
    end

    logic pc_write;
    logic branch;
`ifdef MCP_BNE_EN
    logic branch_n;
`endif

    // Outputs are decoded straight from the state register so that FETCH
    // values are visible in the cycle right after reset is released.
    always_comb begin
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        pc_write = 1'b0;
        branch   = 1'b0;
`ifdef MCP_BNE_EN
        branch_n = 1'b0;
`endif
        case (state_q)
            StFetch: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            StDecode: ALUSrcB = 2'b11;
            StMemAdr, StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: IorD = 1'b1;
            StMemWr: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            StMemWb: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            StExecute: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            StAluWb: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            StAddiWb: RegWrite = 1'b1;
            StBranch: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MCP_BNE_EN
            StBneBr: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSrc    = 2'b01;
                branch_n = 1'b1;
            end
`endif
            StJump: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase

`ifdef MCP_BNE_EN
        PCEn = pc_write | (branch & Zero) | (branch_n & ~Zero);
`else
        PCEn = pc_write | (branch & Zero);
`endif

        // While reset is held, suppress anything that writes architectural state.
        if (RST) begin
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            PCEn     = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_mcp_control_fsm.sv
module tb_mcp_control_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Opcode;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn;
    logic [3:0] State;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef int path_t[$];

    mcp_control_fsm dut (
        .CLK      (CLK),
        .RST      (RST),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSrc    (PCSrc),
        .PCEn     (PCEn),
        .State    (State)
    );

    always #5 CLK = ~CLK;

    logic [13:0] ctrl_obs;
    assign ctrl_obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                       ALUSrcB, ALUOp, PCSrc, PCEn};

    // Reference: state sequence of one instruction, from FETCH to its last state.
    function automatic path_t exp_path(logic [5:0] op);
        path_t p;
        case (op)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000000: p = '{0, 1, 6, 7};
            6'b000100: p = '{0, 1, 8};
            6'b001000: p = '{0, 1, 9, 10};
            6'b000010: p = '{0, 1, 11};
`ifdef MCP_BNE_EN
            6'b000101: p = '{0, 1, 12};
`endif
            default:   p = '{0, 1};
        endcase
        return p;
    endfunction

    // Reference: control table per state code, packed like ctrl_obs.
    function automatic logic [13:0] exp_ctrl(int st, logic z, logic rst);
        logic       iord = 0, memw = 0, irw = 0, regdst = 0, memtoreg = 0, regw = 0;
        logic       srca = 0, pcen = 0;
        logic [1:0] srcb = 0, aluop = 0, pcsrc = 0;
        case (st)
            0:  begin srcb = 2'b01; irw = 1; pcen = 1; end
            1:  srcb = 2'b11;
            2, 9: begin srca = 1; srcb = 2'b10; end
            3:  iord = 1;
            4:  begin memtoreg = 1; regw = 1; end
            5:  begin iord = 1; memw = 1; end
            6:  begin srca = 1; aluop = 2'b10; end
            7:  begin regdst = 1; regw = 1; end
            8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcen = z; end
            10: regw = 1;
            11: begin pcsrc = 2'b10; pcen = 1; end
            12: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcen = ~z; end
            default: ;
        endcase
        if (rst) begin
            irw = 0; memw = 0; regw = 0; pcen = 0;
        end
        return {iord, memw, irw, regdst, memtoreg, regw, srca, srcb, aluop, pcsrc, pcen};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Walks one instruction from FETCH, checking state and controls each cycle.
    // zmode: 0/1 fixed Zero, 2 random. scramble: random Opcode outside DECODE/MEMADR.
    task automatic run_instr(input logic [5:0] op, input int zmode, input bit scramble,
                             input string tag);
        path_t p;
        logic [13:0] exp;
        p = exp_path(op);
        foreach (p[i]) begin
            Opcode = (scramble && p[i] != 1 && p[i] != 2) ? 6'($urandom) : op;
            Zero   = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            #1;
            total_cnt++;
            if (State !== 4'(p[i]))
                $display("FAIL %s state op=%b step %0d: got %0d required %0d",
                         tag, op, i, State, p[i]);
            else pass_cnt++;
            exp = exp_ctrl(p[i], Zero, 1'b0);
            total_cnt++;
            if (ctrl_obs !== exp)
                $display("FAIL %s ctrl op=%b state %0d: got %b required %b",
                         tag, op, p[i], ctrl_obs, exp);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        logic [13:0] exp;
        RST = 1'b1; Opcode = 6'b100011; Zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            exp = exp_ctrl(0, Zero, 1'b1);
            total_cnt++;
            if (State !== 4'd0) $display("FAIL reset_state: got %0d required 0", State);
            else pass_cnt++;
            total_cnt++;
            if (ctrl_obs !== exp)
                $display("FAIL reset_ctrl: got %b required %b", ctrl_obs, exp);
            else pass_cnt++;
        end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        total_cnt++;
        if ({IRWrite, PCEn} !== 2'b11)
            $display("FAIL reset_release_fetch: got IRWrite/PCEn=%b required 11",
                     {IRWrite, PCEn});
        else pass_cnt++;
        run_instr(6'b100011, 0, 0, "lw_after_reset");
    endtask

    task automatic test_instr_classes();
        run_instr(6'b101011, 0, 0, "sw");
        run_instr(6'b000000, 0, 0, "rtype");
        run_instr(6'b001000, 0, 0, "addi");
        run_instr(6'b000010, 1, 0, "j");
        run_instr(6'b111111, 0, 0, "unknown");
    endtask

    task automatic test_branch();
        run_instr(6'b000100, 1, 0, "beq_taken");
        run_instr(6'b000100, 0, 0, "beq_not_taken");
        run_instr(6'b000101, 0, 0, "bne_z0");
        run_instr(6'b000101, 1, 0, "bne_z1");
    endtask

    task automatic test_async_reset();
        Opcode = 6'b101011; Zero = 1'b0;
        step(); step(); step();
        total_cnt++;
        if ({State, MemWrite} !== {4'd5, 1'b1})
            $display("FAIL async_pre: got state %0d MemWrite %b required 5/1", State, MemWrite);
        else pass_cnt++;
        #2;
        RST = 1'b1;
        #1;
        total_cnt++;
        if ({State, MemWrite, PCEn, IRWrite} !== {4'd0, 3'b000})
            $display("FAIL async_reset: got state %0d MemWrite %b PCEn %b IRWrite %b required 0/0/0/0",
                     State, MemWrite, PCEn, IRWrite);
        else pass_cnt++;
        step();
        @(negedge CLK);
        RST = 1'b0;
        run_instr(6'b000000, 0, 0, "rtype_after_async");
    endtask

    task automatic test_opcode_change();
        Opcode = 6'b000000; Zero = 1'b0;
        step(); step();
        total_cnt++;
        if (State !== 4'd6) $display("FAIL opchg_exec: got %0d required 6", State);
        else pass_cnt++;
        Opcode = 6'b101011;
        step();
        total_cnt++;
        if ({State, RegDst, RegWrite} !== {4'd7, 2'b11})
            $display("FAIL opchg_aluwb: got state %0d RegDst %b RegWrite %b required 7/1/1",
                     State, RegDst, RegWrite);
        else pass_cnt++;
        step();
        total_cnt++;
        if (State !== 4'd0) $display("FAIL opchg_return: got %0d required 0", State);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] op;
        int k;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
        for (int n = 0; n < 200; n++) begin
            k  = int'($urandom_range(0, 7));
            op = (k == 7) ? 6'($urandom) : ops[k];
            run_instr(op, 2, 1, "random");
        end
    endtask

    initial begin
        RST = 1'b1;
        Opcode = 6'b000000;
        Zero = 1'b0;
        test_reset();
        test_instr_classes();
        test_branch();
        test_async_reset();
        test_opcode_change();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
